cnt200_dn: RTL and testbench
============================

# cnt200_dn

Loadable modulo-200 down counter/timer: the counting-down counterpart of the mod-200 up counter. It takes a binary preset split across two 4-bit nibbles (QH:QL), counts down once per enabled clock, and emits a one-cycle borrow pulse `B` when the terminal count is consumed. It can be configured for one-shot operation or for periodic reload, giving a divide-by-(N+1) tick.

## Interface
Parameters:
- `MODULUS`, default 200: count range 0..MODULUS-1; legal range 2..256.

Ports:
- `Clk`, input, 1 bit: clock; all state changes on the rising edge.
- `MR`, input, 1 bit: synchronous, active-low reset.
- `Load`, input, 1 bit: one-cycle strobe that captures `D` and starts a count.
- `D`, input, 8 bits: binary preset value.
- `CE`, input, 1 bit: count enable; decrement only when high.
- `QH`, output, 4 bits: high nibble of the current count (count[7:4]).
- `QL`, output, 4 bits: low nibble of the current count (count[3:0]).
- `B`, output, 1 bit: borrow/terminal pulse, registered, high for exactly one cycle.
- `Busy`, output, 1 bit: high while the state is RUN.

## Operation
- **Count representation:** 8-bit binary, `{QH,QL}`, not BCD.
- **States:**
  - IDLE: count holds, `Busy`=0.
  - RUN: count decrements when `CE`=1, `Busy`=1.
- **Priority:** `MR` low > `Load` > `CE`.
- **Load** (any state):
  - Count <= D if D < MODULUS, else MODULUS-1 (clamp).
  - Reload register <= the same value.
  - State <= RUN.
  - `B` <= 0.
- **RUN with CE=1 and count≠0:** count <= count-1; `B` <= 0.
- **RUN with CE=1 and count=0 (terminal):** `B` <= 1 for one cycle, then:
  - Without autoload: state <= IDLE, count stays 0.
  - With autoload: count <= reload value, stay in RUN.
- **RUN with CE=0:** count holds, `B` <= 0.
- **IDLE:** `CE` is ignored and `B` <= 0.
- **Period:** a preset of N yields N+1 enabled cycles from Load to the `B` assertion. With a preset of 199 and autoload, `B` fires every 200 CE cycles.
- **Load in the terminal cycle:** Load wins. No `B` is produced and the count restarts from `D`.
- **Load with D=0:** the next CE cycle is terminal.

## Timing
- **Reset values:** `QH`=0, `QL`=0, `B`=0, `Busy`=0, state IDLE, reload register=0.
- **Reset is synchronous:** `MR` is sampled only on the rising edge of `Clk`. A reset mid-count clears everything at that edge, and `B` is never emitted afterward.
- **Load at edge k:** `{QH,QL}`=D and `Busy`=1 are visible after edge k. The first decrement happens at edge k+1 if `CE`=1.
- **Borrow latency:** `B` rises at the edge that samples count=0 with `CE`=1, and falls at the next edge unless another terminal occurs.
- **Back-to-back terminals:** in autoload mode with a reload value of 0, `B` stays high continuously while `CE`=1.
- **Output timing:** all outputs are registered, with no combinational path from any input to any output.

## Configuration
- **`CNT200_DN_AUTOLOAD_EN` defined:** on terminal, the counter reloads the last loaded value and stays in RUN, producing a periodic `B`.
- **`CNT200_DN_AUTOLOAD_EN` undefined:** one-shot operation. On terminal, the counter goes to IDLE with count 0 and waits for the next `Load`. The reload register may be optimised away.

## Test plan
- **Reset:** hold `MR`=0 for 2 cycles with Load=1 and D=0x55 -> `QH`=0, `QL`=0, `B`=0, `Busy`=0. Release `MR` -> outputs remain 0 until the first Load.
- **One-shot:** Load with D=5, then `CE`=1 continuously -> count goes 5,4,3,2,1,0. `B`=1 on the 6th enabled edge, then IDLE with `Busy`=0 and count 0.
- **Autoload (macro defined):** Load with D=199, then `CE`=1 for 600 cycles -> exactly 3 `B` pulses, 200 cycles apart. `{QH,QL}`=0xC7 after each pulse.
- **Clamp and gating:**
  - Load with D=250 -> `{QH,QL}`=0xC7.
  - Toggle `CE` 1,0,1 -> the count decrements only on CE=1 edges.
- **Load vs terminal:** Load with D=7 asserted in the same cycle that count=0 with `CE`=1 -> `B` stays 0, count becomes 7, `Busy`=1.
- **Reset mid-run:** Load with D=10, run 4 cycles, then `MR`=0 for 1 cycle -> count 0, `Busy`=0, and no `B` afterward.

Source files
------------

// File: rtl/cnt200_dn.sv
// ---------------------------------------------------------------------------
// cnt200_dn -- loadable modulo-MODULUS down counter / timer
//
// A binary preset is captured on Load, clamped into 0..MODULUS-1, and then
// decremented once per enabled clock. When a count of zero is consumed with
// CE high, a registered one-cycle borrow pulse B is produced. After that,
// the counter either stops (one-shot) or reloads the last preset (periodic).
//
// Build option:
//   CNT200_DN_AUTOLOAD_EN  defined   -> periodic reload on terminal count
//                          undefined -> one-shot, returns to IDLE at count 0
//
// Parameters:
//   MODULUS  count range 0..MODULUS-1, legal 2..256 (default 200)
//
// Ports:
//   Clk   in   clock, rising edge
//   MR    in   synchronous active-low reset
//   Load  in   strobe: capture D (clamped) and enter RUN
//   D     in   [7:0] binary preset
//   CE    in   count enable
//   QH    out  [3:0] count[7:4]
//   QL    out  [3:0] count[3:0]
//   B     out  registered borrow pulse
//   Busy  out  high while in RUN
// ---------------------------------------------------------------------------
module cnt200_dn #(
    parameter int MODULUS = 200
) (
    input  logic       Clk,
    input  logic       MR,
    input  logic       Load,
    input  logic [7:0] D,
    input  logic       CE,
    output logic [3:0] QH,
    output logic [3:0] QL,
    output logic       B,
    output logic       Busy
);

    // 9-bit compare value so that MODULUS=256 is representable.
    localparam logic [8:0] LP_MOD = 9'(MODULUS);
    localparam logic [7:0] LP_MAX = 8'(MODULUS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_count;
    logic [7:0] w_count_next;
    logic       r_b;
    logic       w_b_next;
    logic [7:0] w_preset;
    logic       w_terminal;

`ifdef CNT200_DN_AUTOLOAD_EN
    logic [7:0] r_reload;
    logic [7:0] w_reload_next;
`endif

    // Out-of-range presets saturate to the top of the count range.
    assign w_preset   = ({1'b0, D} < LP_MOD) ? D : LP_MAX;
    assign w_terminal = (r_state == ST_RUN) && CE && (r_count == 8'd0);

    // -----------------------------------------------------------------------
    // State / datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!MR) begin
            r_state  <= ST_IDLE;
            r_count  <= 8'd0;
            r_b      <= 1'b0;
`ifdef CNT200_DN_AUTOLOAD_EN
            r_reload <= 8'd0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_b      <= w_b_next;
`ifdef CNT200_DN_AUTOLOAD_EN
            r_reload <= w_reload_next;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. Load overrides everything (including a terminal
    // cycle), so a Load coinciding with count 0 suppresses the borrow.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_b_next      = 1'b0;
`ifdef CNT200_DN_AUTOLOAD_EN
        w_reload_next = r_reload;
`endif

        if (Load) begin
            w_state_next  = ST_RUN;
            w_count_next  = w_preset;
`ifdef CNT200_DN_AUTOLOAD_EN
            w_reload_next = w_preset;
`endif
        end else if (w_terminal) begin
            w_b_next = 1'b1;
`ifdef CNT200_DN_AUTOLOAD_EN
            // Periodic mode: restart from the stored preset, stay running.
            w_count_next = r_reload;
            w_state_next = ST_RUN;
`else
            // One-shot mode: park at zero until the next Load.
            w_count_next = 8'd0;
            w_state_next = ST_IDLE;
`endif
        end else if ((r_state == ST_RUN) && CE) begin
            w_count_next = r_count - 8'd1;
        end
    end

    // All outputs come straight from registers.
    assign QH   = r_count[7:4];
    assign QL   = r_count[3:0];
    assign B    = r_b;
    assign Busy = (r_state == ST_RUN);

endmodule

// File: tb/tb_cnt200_dn.sv
// ---------------------------------------------------------------------------
// tb_cnt200_dn -- self-checking bench for cnt200_dn
//
// Directed scenarios followed by a randomized run. Every cycle the outputs
// are compared with a behavioural model that tracks the count as an integer
// together with a "running" flag and the last clamped preset.
// Follows CNT200_DN_AUTOLOAD_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_cnt200_dn;

    localparam int MOD = 200;

    logic       Clk = 1'b0;
    logic       MR = 1'b0;
    logic       Load = 1'b0;
    logic [7:0] D = 8'd0;
    logic       CE = 1'b0;
    logic [3:0] QH;
    logic [3:0] QL;
    logic       B;
    logic       Busy;

    cnt200_dn #(.MODULUS(MOD)) dut (
        .Clk  (Clk),
        .MR   (MR),
        .Load (Load),
        .D    (D),
        .CE   (CE),
        .QH   (QH),
        .QL   (QL),
        .B    (B),
        .Busy (Busy)
    );

    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference state
    int m_cnt     = 0;
    int m_reload  = 0;
    bit m_running = 0;
    bit m_b       = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected behaviour of one clock edge given the inputs it samples.
    task automatic model_edge(input bit mr, input bit ld, input int d, input bit ce);
        m_b = 0;
        if (!mr) begin
            m_cnt = 0; m_reload = 0; m_running = 0;
        end else if (ld) begin
            m_cnt     = (d < MOD) ? d : MOD - 1;
            m_reload  = m_cnt;
            m_running = 1;
        end else if (m_running && ce) begin
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
            end else begin
                m_b = 1;
`ifdef CNT200_DN_AUTOLOAD_EN
                m_cnt = m_reload;
`else
                m_running = 0;
`endif
            end
        end
    endtask

    // Drive one cycle, advance model, compare all outputs after the edge.
    task automatic step(input bit mr, input bit ld, input int d, input bit ce);
        MR = mr; Load = ld; D = 8'(d); CE = ce;
        @(posedge Clk);
        #1;
        model_edge(mr, ld, d, ce);
        check_val("cycle_count", int'({QH, QL}), m_cnt);
        check_val("cycle_B", int'(B), int'(m_b));
        check_val("cycle_Busy", int'(Busy), int'(m_running));
        $display("cyc mr=%0b ld=%0b d=%0d ce=%0b -> cnt=%0d B=%0b Busy=%0b",
                 mr, ld, d, ce, {QH, QL}, B, Busy);
    endtask

    initial begin
        int pulses;
        int first_at;
        int last_at;

        // ---- Reset held with Load active ----
        step(0, 1, 'h55, 1);
        step(0, 1, 'h55, 1);
        check_val("rst_count", int'({QH, QL}), 0);
        check_val("rst_busy", int'(Busy), 0);
        check_val("rst_b", int'(B), 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        check_val("post_rst_count", int'({QH, QL}), 0);
        check_val("post_rst_busy", int'(Busy), 0);

        // ---- One-shot from 5 ----
        step(1, 1, 5, 0);
        check_val("load5_count", int'({QH, QL}), 5);
        check_val("load5_busy", int'(Busy), 1);
        for (int i = 4; i >= 0; i--) begin
            step(1, 0, 0, 1);
            check_val("dec_count", int'({QH, QL}), i);
            check_val("dec_b", int'(B), 0);
        end
        step(1, 0, 0, 1);
        check_val("term_b", int'(B), 1);
`ifdef CNT200_DN_AUTOLOAD_EN
        check_val("term_busy", int'(Busy), 1);
        check_val("term_count", int'({QH, QL}), 5);
`else
        check_val("term_busy", int'(Busy), 0);
        check_val("term_count", int'({QH, QL}), 0);
`endif
        step(1, 0, 0, 1);
        check_val("term_b_fall", int'(B), 0);

        // ---- Clamp and CE gating ----
        step(1, 1, 250, 0);
        check_val("clamp", int'({QH, QL}), 'hC7);
        step(1, 0, 0, 1);
        check_val("gate_ce1", int'({QH, QL}), 'hC6);
        step(1, 0, 0, 0);
        check_val("gate_ce0", int'({QH, QL}), 'hC6);
        step(1, 0, 0, 1);
        check_val("gate_ce1b", int'({QH, QL}), 'hC5);

        // ---- Load wins over terminal ----
        step(1, 1, 2, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        check_val("lvt_zero", int'({QH, QL}), 0);
        step(1, 1, 7, 1);
        check_val("lvt_b", int'(B), 0);
        check_val("lvt_count", int'({QH, QL}), 7);
        check_val("lvt_busy", int'(Busy), 1);

        // ---- Load 0: next CE edge is terminal ----
        step(1, 1, 0, 0);
        step(1, 0, 0, 1);
        check_val("load0_b", int'(B), 1);

        // ---- Reset mid-run ----
        step(1, 1, 10, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
        check_val("mid_count", int'({QH, QL}), 6);
        step(0, 0, 0, 1);
        check_val("mid_rst_count", int'({QH, QL}), 0);
        check_val("mid_rst_busy", int'(Busy), 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 1);
            if (B) pulses++;
        end
        check_val("mid_rst_no_b", pulses, 0);

        // ---- Period with preset 199 over 600 enabled cycles ----
        step(1, 1, 199, 0);
        pulses = 0; first_at = -1; last_at = -1;
        for (int i = 1; i <= 600; i++) begin
            step(1, 0, 0, 1);
            if (B) begin
                pulses++;
                if (first_at < 0) first_at = i;
                else check_val("period_gap", i - last_at, 200);
                last_at = i;
`ifdef CNT200_DN_AUTOLOAD_EN
                check_val("period_reload", int'({QH, QL}), 'hC7);
`endif
            end
        end
        check_val("period_first", first_at, 200);
`ifdef CNT200_DN_AUTOLOAD_EN
        check_val("period_pulses", pulses, 3);
`else
        check_val("period_pulses", pulses, 1);
`endif

        // ---- Randomized run ----
        for (int i = 0; i < 3000; i++) begin
            bit r_mr;
            bit r_ld;
            bit r_ce;
            int r_d;
            r_mr = ($urandom_range(0, 99) != 0);
            r_ld = ($urandom_range(0, 99) < 4);
            r_ce = ($urandom_range(0, 99) < 75);
            r_d  = (($urandom & 3) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 255);
            step(r_mr, r_ld, r_d, r_ce);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
